// File: rtl/dmix_pkg.sv
// Shared defaults for the audio-mix blocks: channel count, ring depth and sample width.
package dmix_pkg;

    localparam int DMIX_NUM_CH      = 2;
    localparam int DMIX_NUM_CH_LOG2 = 1;
    localparam int DMIX_LEN         = 64;
    localparam int DMIX_LEN_LOG2    = 6;
    localparam int DMIX_DATA_W      = 24;

endpackage

// File: rtl/ringbuf_ctl.sv
// Pointer, fill-count and sticky-status logic for one ring-buffer channel.
// Status flags exist only when MC_RINGBUF_STATUS_EN is defined; otherwise they are tied low.
module ringbuf_ctl
    import dmix_pkg::*;
#(
    parameter int LEN      = DMIX_LEN,
    parameter int LEN_LOG2 = DMIX_LEN_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic                pop,
    input  logic                clr,
    input  logic                rd_miss,
    output logic                wr_en,
    output logic [LEN_LOG2-1:0] wr_ptr,
    output logic [LEN_LOG2-1:0] rd_ptr,
    output logic [LEN_LOG2:0]   count,
    output logic                ovf,
    output logic                unf
);

    localparam logic [LEN_LOG2:0] FULL = (LEN_LOG2 + 1)'(LEN);

    logic pop_en;

    // A pop in the same cycle frees a slot, so a full buffer still accepts that write.
    assign pop_en = pop && (count != '0);
    assign wr_en  = we && ((count != FULL) || pop_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop_en)
                count <= count + 1'b1;
            else if (pop_en && !wr_en)
                count <= count - 1'b1;
        end
    end

`ifdef MC_RINGBUF_STATUS_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = we && !wr_en;
    assign unf_set = (pop && !pop_en) || rd_miss;

    // A set event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~clr);
            unf <= unf_set | (unf & ~clr);
        end
    end
`else
    logic unused_status;

    assign unused_status = clr ^ rd_miss;
    assign ovf           = 1'b0;
    assign unf           = 1'b0;
`endif

endmodule

// File: rtl/mc_ringbuf.sv
// Multi-channel ring buffer: per-channel storage with a registered random-offset read port.
// Define MC_RINGBUF_STATUS_EN to enable level_o, ovf_o, unf_o and clr_i.
module mc_ringbuf
    import dmix_pkg::*;
#(
    parameter int NUM_CH      = DMIX_NUM_CH,
    parameter int NUM_CH_LOG2 = DMIX_NUM_CH_LOG2,
    parameter int LEN         = DMIX_LEN,
    parameter int LEN_LOG2    = DMIX_LEN_LOG2,
    parameter int DATA_W      = DMIX_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*DATA_W-1:0]       data_i,
    input  logic [NUM_CH-1:0]              we_i,
    input  logic [NUM_CH-1:0]              pop_i,
    input  logic [NUM_CH_LOG2-1:0]         rd_ch_i,
    input  logic [LEN_LOG2-1:0]            offset_i,
    output logic [DATA_W-1:0]              data_o,
    input  logic [NUM_CH-1:0]              clr_i,
    output logic [NUM_CH*(LEN_LOG2+1)-1:0] level_o,
    output logic [NUM_CH-1:0]              ovf_o,
    output logic [NUM_CH-1:0]              unf_o
);

    localparam int CNT_W = LEN_LOG2 + 1;

    logic [LEN_LOG2-1:0] wr_ptr  [NUM_CH];
    logic [LEN_LOG2-1:0] rd_ptr  [NUM_CH];
    logic [CNT_W-1:0]    count   [NUM_CH];
    logic [DATA_W-1:0]   rd_word [NUM_CH];
    logic [NUM_CH-1:0]   wr_en;
    logic [NUM_CH-1:0]   rd_miss;
    logic                rd_ch_valid;

    assign rd_ch_valid = 32'(rd_ch_i) < NUM_CH;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0]   mem [LEN];
        logic [LEN_LOG2-1:0] rd_addr;

        // Reading at or past the fill count is a miss; it returns zero and flags underrun.
        assign rd_miss[c] = (32'(rd_ch_i) == c) && ({1'b0, offset_i} >= count[c]);

        ringbuf_ctl #(
            .LEN      (LEN),
            .LEN_LOG2 (LEN_LOG2)
        ) u_ctl (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (we_i[c]),
            .pop     (pop_i[c]),
            .clr     (clr_i[c]),
            .rd_miss (rd_miss[c]),
            .wr_en   (wr_en[c]),
            .wr_ptr  (wr_ptr[c]),
            .rd_ptr  (rd_ptr[c]),
            .count   (count[c]),
            .ovf     (ovf_o[c]),
            .unf     (unf_o[c])
        );

        always_ff @(posedge clk) begin
            if (wr_en[c])
                mem[wr_ptr[c]] <= data_i[c*DATA_W +: DATA_W];
        end

        assign rd_addr    = rd_ptr[c] + offset_i;
        assign rd_word[c] = mem[rd_addr];

`ifdef MC_RINGBUF_STATUS_EN
        assign level_o[c*CNT_W +: CNT_W] = count[c];
`endif
    end

`ifndef MC_RINGBUF_STATUS_EN
    assign level_o = '0;
`endif

    // Storage is never reset, so a miss must force zero rather than expose stale words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_o <= '0;
        else if (rd_ch_valid && (rd_miss == '0))
            data_o <= rd_word[rd_ch_i];
        else
            data_o <= '0;
    end

endmodule

// File: tb/tb_mc_ringbuf.sv
// Self-checking bench for mc_ringbuf against a queue-based channel model.
// Status expectations follow MC_RINGBUF_STATUS_EN; without it they are zero.
module tb_mc_ringbuf;

    localparam int NUM_CH      = 2;
    localparam int NUM_CH_LOG2 = 1;
    localparam int LEN         = 64;
    localparam int LEN_LOG2    = 6;
    localparam int DATA_W      = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] data_i;
    logic [1:0]  we_i;
    logic [1:0]  pop_i;
    logic [0:0]  rd_ch_i;
    logic [5:0]  offset_i;
    logic [23:0] data_o;
    logic [1:0]  clr_i;
    logic [13:0] level_o;
    logic [1:0]  ovf_o;
    logic [1:0]  unf_o;

    bit   [23:0] mq [2][$];
    bit   [1:0]  m_ovf;
    bit   [1:0]  m_unf;
    logic [23:0] exp_data;
    int          n_cmp;
    int          n_bad;

    mc_ringbuf #(
        .NUM_CH      (NUM_CH),
        .NUM_CH_LOG2 (NUM_CH_LOG2),
        .LEN         (LEN),
        .LEN_LOG2    (LEN_LOG2),
        .DATA_W      (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .we_i     (we_i),
        .pop_i    (pop_i),
        .rd_ch_i  (rd_ch_i),
        .offset_i (offset_i),
        .data_o   (data_o),
        .clr_i    (clr_i),
        .level_o  (level_o),
        .ovf_o    (ovf_o),
        .unf_o    (unf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_level();
`ifdef MC_RINGBUF_STATUS_EN
        return {7'(mq[1].size()), 7'(mq[0].size())};
`else
        return '0;
`endif
    endfunction

    function automatic logic [1:0] exp_ovf();
`ifdef MC_RINGBUF_STATUS_EN
        return m_ovf;
`else
        return '0;
`endif
    endfunction

    function automatic logic [1:0] exp_unf();
`ifdef MC_RINGBUF_STATUS_EN
        return m_unf;
`else
        return '0;
`endif
    endfunction

    // One clock: drive inputs, predict from the queues' pre-edge contents, then apply the edge.
    task automatic drive_cycle(input logic [1:0] we, input logic [1:0] pop, input logic [1:0] clr,
                               input logic [23:0] d0, input logic [23:0] d1,
                               input int rch, input int off);
        bit [1:0] ovf_set;
        bit [1:0] unf_set;
        bit [1:0] pop_ok;
        bit [1:0] wr_ok;
        we_i     = we;
        pop_i    = pop;
        clr_i    = clr;
        data_i   = {d1, d0};
        rd_ch_i  = 1'(rch);
        offset_i = 6'(off);
        ovf_set  = '0;
        unf_set  = '0;
        if (off < mq[rch].size()) begin
            exp_data = mq[rch][off];
        end else begin
            exp_data     = '0;
            unf_set[rch] = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            pop_ok[c] = pop[c] && (mq[c].size() > 0);
            wr_ok[c]  = we[c] && ((mq[c].size() < LEN) || pop_ok[c]);
            if (pop[c] && !pop_ok[c]) unf_set[c] = 1'b1;
            if (we[c] && !wr_ok[c]) ovf_set[c] = 1'b1;
        end
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_ok[c]) void'(mq[c].pop_front());
            if (wr_ok[c]) mq[c].push_back((c == 0) ? d0 : d1);
        end
        m_ovf = ovf_set | (m_ovf & ~clr);
        m_unf = unf_set | (m_unf & ~clr);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        we_i     = '0;
        pop_i    = '0;
        clr_i    = '0;
        data_i   = '0;
        rd_ch_i  = '0;
        offset_i = '0;
        #1;
        n_cmp++;
        if (data_o !== 24'h0) begin n_bad++; $display("[TB] FAIL reset_data: got %h want %h", data_o, 24'h0); end
        n_cmp++;
        if (level_o !== 14'h0) begin n_bad++; $display("[TB] FAIL reset_level: got %h want %h", level_o, 14'h0); end
        n_cmp++;
        if (ovf_o !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_ovf: got %b want %b", ovf_o, 2'b00); end
        n_cmp++;
        if (unf_o !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_unf: got %b want %b", unf_o, 2'b00); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_read();
        for (int k = 1; k <= 5; k++)
            drive_cycle(2'b01, 2'b00, 2'b00, 24'(k), 24'h0, 0, 0);
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 2);
        n_cmp++;
        if (data_o !== 24'h000003) begin n_bad++; $display("[TB] FAIL basic_offset2: got %h want %h", data_o, 24'h000003); end
        n_cmp++;
        if (level_o !== exp_level()) begin n_bad++; $display("[TB] FAIL basic_level: got %h want %h", level_o, exp_level()); end
        n_cmp++;
        if (unf_o !== exp_unf()) begin n_bad++; $display("[TB] FAIL basic_unf: got %b want %b", unf_o, exp_unf()); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < LEN; k++)
            drive_cycle(2'b10, 2'b00, 2'b00, 24'h0, 24'($urandom), 0, 0);
        drive_cycle(2'b10, 2'b00, 2'b00, 24'h0, 24'hABCDEF, 0, 0);
        n_cmp++;
        if (ovf_o !== exp_ovf()) begin n_bad++; $display("[TB] FAIL ovf_drop: got %b want %b", ovf_o, exp_ovf()); end
        n_cmp++;
        if (level_o !== exp_level()) begin n_bad++; $display("[TB] FAIL ovf_level: got %h want %h", level_o, exp_level()); end
        drive_cycle(2'b10, 2'b10, 2'b00, 24'h0, 24'h5A5A5A, 1, 0);
        n_cmp++;
        if (level_o !== exp_level()) begin n_bad++; $display("[TB] FAIL full_wrpop_level: got %h want %h", level_o, exp_level()); end
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 1, 63);
        n_cmp++;
        if (data_o !== 24'h5A5A5A) begin n_bad++; $display("[TB] FAIL full_wrpop_data: got %h want %h", data_o, 24'h5A5A5A); end
    endtask

    task automatic test_underrun();
        for (int k = 0; k < 5; k++)
            drive_cycle(2'b00, 2'b01, 2'b00, 24'h0, 24'h0, 1, 0);
        drive_cycle(2'b00, 2'b01, 2'b00, 24'h0, 24'h0, 1, 0);
        n_cmp++;
        if (unf_o !== exp_unf()) begin n_bad++; $display("[TB] FAIL unf_set: got %b want %b", unf_o, exp_unf()); end
        drive_cycle(2'b00, 2'b00, 2'b01, 24'h0, 24'h0, 1, 0);
        n_cmp++;
        if (unf_o !== exp_unf()) begin n_bad++; $display("[TB] FAIL unf_clear: got %b want %b", unf_o, exp_unf()); end
        drive_cycle(2'b01, 2'b00, 2'b00, 24'h777777, 24'h0, 1, 0);
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 0);
        n_cmp++;
        if (data_o !== 24'h777777) begin n_bad++; $display("[TB] FAIL unf_ptr_hold: got %h want %h", data_o, 24'h777777); end
    endtask

    task automatic test_wrap();
        drive_cycle(2'b00, 2'b01, 2'b00, 24'h0, 24'h0, 1, 0);
        for (int k = 1; k <= 70; k++)
            drive_cycle(2'b01, {1'b0, k > 64}, 2'b00, 24'(32'h100 + k), 24'h0, 1, 0);
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 63);
        n_cmp++;
        if (data_o !== 24'h000146) begin n_bad++; $display("[TB] FAIL wrap_word70: got %h want %h", data_o, 24'h000146); end
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 0);
        n_cmp++;
        if (data_o !== exp_data) begin n_bad++; $display("[TB] FAIL wrap_oldest: got %h want %h", data_o, exp_data); end
    endtask

    task automatic test_concurrent();
        for (int k = 0; k < LEN; k++)
            drive_cycle(2'b00, 2'b11, 2'b00, 24'h0, 24'h0, 0, 0);
        drive_cycle(2'b11, 2'b00, 2'b00, 24'h111111, 24'h222222, 0, 0);
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 0);
        n_cmp++;
        if (data_o !== 24'h111111) begin n_bad++; $display("[TB] FAIL conc_ch0: got %h want %h", data_o, 24'h111111); end
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 1, 0);
        n_cmp++;
        if (data_o !== 24'h222222) begin n_bad++; $display("[TB] FAIL conc_ch1: got %h want %h", data_o, 24'h222222); end
        n_cmp++;
        if (level_o !== exp_level()) begin n_bad++; $display("[TB] FAIL conc_level: got %h want %h", level_o, exp_level()); end
    endtask

    task automatic test_reset_midstream();
        while (mq[0].size() < 10)
            drive_cycle(2'b01, 2'b00, 2'b00, 24'($urandom), 24'h0, 0, 0);
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data_o !== 24'h0) begin n_bad++; $display("[TB] FAIL mid_reset_data: got %h want %h", data_o, 24'h0); end
        n_cmp++;
        if (level_o !== 14'h0) begin n_bad++; $display("[TB] FAIL mid_reset_level: got %h want %h", level_o, 14'h0); end
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_ovf = '0;
        m_unf = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 0, 0);
        n_cmp++;
        if (data_o !== 24'h0) begin n_bad++; $display("[TB] FAIL post_reset_read: got %h want %h", data_o, 24'h0); end
        n_cmp++;
        if (unf_o !== exp_unf()) begin n_bad++; $display("[TB] FAIL post_reset_unf: got %b want %b", unf_o, exp_unf()); end
    endtask

    task automatic test_random();
        logic [1:0] we;
        logic [1:0] pop;
        logic [1:0] clr;
        for (int n = 0; n < 600; n++) begin
            we  = 2'($urandom);
            pop = (n % 200 < 100) ? 2'($urandom & $urandom & $urandom) : 2'($urandom);
            clr = (($urandom % 8) == 0) ? 2'($urandom) : 2'b00;
            drive_cycle(we, pop, clr, 24'($urandom), 24'($urandom),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            n_cmp++;
            if (data_o !== exp_data) begin n_bad++; $display("[TB] FAIL rand_data[%0d]: got %h want %h", n, data_o, exp_data); end
            n_cmp++;
            if (level_o !== exp_level()) begin n_bad++; $display("[TB] FAIL rand_level[%0d]: got %h want %h", n, level_o, exp_level()); end
            n_cmp++;
            if (ovf_o !== exp_ovf()) begin n_bad++; $display("[TB] FAIL rand_ovf[%0d]: got %b want %b", n, ovf_o, exp_ovf()); end
            n_cmp++;
            if (unf_o !== exp_unf()) begin n_bad++; $display("[TB] FAIL rand_unf[%0d]: got %b want %b", n, unf_o, exp_unf()); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_ovf = '0;
        m_unf = '0;
        test_reset();
        test_basic_read();
        test_overflow();
        test_underrun();
        test_wrap();
        test_concurrent();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
